// File: rtl/note_envelope.sv
// rtl/note_envelope.sv - attack/release gain stage for note samples; optional release ramp via NOTE_ENVELOPE_RELEASE_EN
module note_envelope #(
   parameter int GAIN_BITS    = 8,
   parameter int ATTACK_STEP  = 8,
   parameter int RELEASE_STEP = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  play_enable,
   input  logic                  note_start,
   input  logic                  note_end,
   input  logic signed [15:0]    sample_in,
   input  logic                  sample_in_ready,
   output logic signed [15:0]    sample_out,
   output logic                  sample_out_ready,
   output logic [GAIN_BITS:0]    gain
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam int PW = 16 + GAIN_BITS + 2;
   localparam logic [GAIN_BITS+1:0] UNITY_W = (GAIN_BITS+2)'(1 << GAIN_BITS);
   localparam logic [GAIN_BITS:0]   UNITY   = (GAIN_BITS+1)'(1 << GAIN_BITS);
   localparam logic [GAIN_BITS+1:0] ATK_W   = (GAIN_BITS+2)'(ATTACK_STEP);
`ifdef NOTE_ENVELOPE_RELEASE_EN
   localparam logic [GAIN_BITS:0]   REL     = (GAIN_BITS+1)'(RELEASE_STEP);
`endif

   state_t                state_q, state_d;
   logic [GAIN_BITS:0]    gain_q, gain_d;
   logic [GAIN_BITS+1:0]  attack_sum;
   logic signed [PW-1:0]  sample_ext, gain_ext, product, shifted;
   logic signed [15:0]    scaled;
   logic                  unused_bits;

   // Scale by the gain held before this cycle's step; the shift floors toward -inf
   always_comb begin
      sample_ext = PW'(sample_in);
      gain_ext   = PW'(gain_q);
      product    = sample_ext * gain_ext;
      shifted    = product >>> GAIN_BITS;
      scaled     = shifted[15:0];
   end

`ifdef NOTE_ENVELOPE_RELEASE_EN
   assign unused_bits = ^{shifted[PW-1:16]};
`else
   assign unused_bits = ^{shifted[PW-1:16], (RELEASE_STEP != 0)};
`endif

   // Next state and gain: note strobes first, then one step chosen by the resulting state
   always_comb begin
      state_d    = state_q;
      gain_d     = gain_q;
      attack_sum = {1'b0, gain_q} + ATK_W;
      if (note_start) begin
         state_d = ATTACK;
      end else if (note_end && (state_q == ATTACK || state_q == SUSTAIN)) begin
`ifdef NOTE_ENVELOPE_RELEASE_EN
         state_d = RELEASE;
`else
         state_d = IDLE;
         gain_d  = '0;
`endif
      end
      if (sample_in_ready && play_enable) begin
         case (state_d)
            ATTACK: begin
               if (attack_sum >= UNITY_W) begin
                  gain_d  = UNITY;
                  state_d = SUSTAIN;
               end else begin
                  gain_d = attack_sum[GAIN_BITS:0];
               end
            end
`ifdef NOTE_ENVELOPE_RELEASE_EN
            RELEASE: begin
               if (gain_q <= REL) begin
                  gain_d  = '0;
                  state_d = IDLE;
               end else begin
                  gain_d = gain_q - REL;
               end
            end
`endif
            default: begin
            end
         endcase
      end
   end

   // State, gain and registered output sample
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         gain_q           <= '0;
         sample_out       <= '0;
         sample_out_ready <= 1'b0;
      end else begin
         state_q          <= state_d;
         gain_q           <= gain_d;
         sample_out_ready <= sample_in_ready;
         if (sample_in_ready) begin
            sample_out <= scaled;
         end
      end
   end

   assign gain = gain_q;

endmodule
